// File: rtl/wbu_fifo_drain_if.sv
// wbu_fifo_drain_if: FIFO read port plus transmitter byte handshake for the
// wbubus return-path drain. master = the drain block, slave = FIFO/transmitter side.
interface wbu_fifo_drain_if;
    logic        i_empty_n;
    logic [35:0] i_data;
    logic        o_rd;
    logic        o_tx_stb;
    logic [7:0]  o_tx_data;
    logic        i_tx_busy;
    logic        o_busy;

    modport master (
        input  i_empty_n, i_data, i_tx_busy,
        output o_rd, o_tx_stb, o_tx_data, o_busy
    );

    modport slave (
        output i_empty_n, i_data, i_tx_busy,
        input  o_rd, o_tx_stb, o_tx_data, o_busy
    );
endinterface

// File: rtl/wbu_fifo_drain.sv
// wbu_fifo_drain: pops 36-bit codewords from the return FIFO and sends each as
// six printable characters (6 bits each, MSB first) followed by an EOL byte.
// Optional idle keep-alive: define WBU_IDLE_EN to emit IDLE_WORD after 2^LGIDLE-1
// empty IDLE cycles.
module wbu_fifo_drain #(
    parameter int          LGIDLE    = 20,
    parameter logic [7:0]  EOL       = 8'h0a,
    parameter logic [35:0] IDLE_WORD = 36'h0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    wbu_fifo_drain_if.master  bus
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_EOL} state_t;

    state_t      state, state_nx;
    logic [35:0] sreg, sreg_nx;
    logic [2:0]  idx, idx_nx;
    logic        stb_nx;
    logic [7:0]  data_nx;
    logic        busy_nx;
    logic        accept;
    logic        start;
    logic [35:0] start_word;

    // 6-bit value to printable character; bit 7 is always zero
    function automatic logic [7:0] enc(input logic [5:0] v);
        logic [7:0] w;
        w = {2'b00, v};
        if (v < 6'd10)      return 8'h30 + w;
        else if (v < 6'd36) return 8'h37 + w;
        else if (v < 6'd62) return 8'h3D + w;
        else if (v == 6'd62) return 8'h40;
        else                return 8'h25;
    endfunction

    // Only pop in IDLE and never while reset is held
    assign bus.o_rd   = i_reset_n && (state == S_IDLE) && bus.i_empty_n;
    assign accept     = bus.o_tx_stb && !bus.i_tx_busy;
    // A timeout only starts when o_rd is low, so the mux never hides a real word
    assign start_word = bus.o_rd ? bus.i_data : IDLE_WORD;

`ifdef WBU_IDLE_EN
    logic [LGIDLE-1:0] idle_cnt, idle_cnt_nx;
    logic              timeout;

    assign timeout = (state == S_IDLE) && !bus.i_empty_n && (&idle_cnt);
    assign start   = bus.o_rd || timeout;

    // Idle counter: runs only while IDLE and empty, clears on any start or outside IDLE
    always_comb begin
        idle_cnt_nx = idle_cnt;
        if (state != S_IDLE || bus.o_rd || timeout)
            idle_cnt_nx = '0;
        else if (!bus.i_empty_n)
            idle_cnt_nx = idle_cnt + 1'b1;
    end

    // Idle counter register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) idle_cnt <= '0;
        else            idle_cnt <= idle_cnt_nx;
    end
`else
    assign start = bus.o_rd;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_nx = state;
        sreg_nx  = sreg;
        idx_nx   = idx;
        stb_nx   = bus.o_tx_stb;
        data_nx  = bus.o_tx_data;
        case (state)
            S_IDLE: begin
                if (start) begin
                    sreg_nx  = start_word;
                    idx_nx   = 3'd0;
                    stb_nx   = 1'b1;
                    data_nx  = enc(start_word[35:30]);
                    state_nx = S_SEND;
                end
            end
            S_SEND: begin
                if (accept) begin
                    if (idx != 3'd5) begin
                        sreg_nx = sreg << 6;
                        idx_nx  = idx + 3'd1;
                        data_nx = enc(sreg[29:24]);
                    end else begin
                        data_nx  = EOL;
                        state_nx = S_EOL;
                    end
                end
            end
            S_EOL: begin
                if (accept) begin
                    stb_nx   = 1'b0;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        busy_nx = (state_nx != S_IDLE);
    end

    // Control and output registers; a partially sent word is dropped on reset
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state         <= S_IDLE;
            idx           <= 3'd0;
            bus.o_tx_stb  <= 1'b0;
            bus.o_tx_data <= 8'h00;
            bus.o_busy    <= 1'b0;
        end else begin
            state         <= state_nx;
            idx           <= idx_nx;
            bus.o_tx_stb  <= stb_nx;
            bus.o_tx_data <= data_nx;
            bus.o_busy    <= busy_nx;
        end
    end

    // Codeword shift register; contents are don't-care until the next capture
    always_ff @(posedge i_clk) begin
        sreg <= sreg_nx;
    end

endmodule
